// File: rtl/fib_number_checker_if.sv
// rtl/fib_number_checker_if.sv - go/done handshake and result bundle for the Fibonacci checker
interface fib_number_checker_if #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 5
);
  logic                 go;
  logic [WIDTH-1:0]     numberIn;
  logic                 done;
  logic                 busy;
  logic                 isFib;
  logic [IDX_WIDTH-1:0] index;

  // Requester side: issues go with a value, observes status and result
  modport master (
    output go,
    output numberIn,
    input  done,
    input  busy,
    input  isFib,
    input  index
  );

  // Checker side
  modport slave (
    input  go,
    input  numberIn,
    output done,
    output busy,
    output isFib,
    output index
  );
endinterface

// File: rtl/fib_number_checker.sv
// rtl/fib_number_checker.sv - iterative Fibonacci membership test, reports exact or floor index
module fib_number_checker #(
  parameter int WIDTH     = 16,
  parameter int IDX_WIDTH = 5,
  parameter int MAX_IDX   = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  fib_number_checker_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;

  logic [WIDTH-1:0]     target;
  logic [WIDTH-1:0]     a;
  logic [WIDTH:0]       b;
  logic [IDX_WIDTH-1:0] k;
  logic                 is_fib_q;
  logic [IDX_WIDTH-1:0] index_q;

  logic                 start;
  logic                 hit;
  logic                 over;
  logic                 at_max;
  logic                 finish;

  // go is only honoured when no search is in flight
  assign start  = bus.go && ((state == IDLE) || (state == DONE));
  assign hit    = (a == target);
  assign over   = (a > target);
  assign at_max = (k == IDX_WIDTH'(MAX_IDX));
  // When none of hit/over holds, a < target, so at_max alone means the value exceeds the last term
  assign finish = hit || over || at_max;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start from IDLE/DONE, leave RUN once the walk resolves
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    if (start)  state_next = RUN;
      default:             state_next = IDLE;
    endcase
  end

  // Status outputs decode straight from the state so reset clears them immediately
  always_comb begin
    bus.done  = (state == DONE);
    bus.busy  = (state == RUN);
    bus.isFib = is_fib_q;
    bus.index = index_q;
  end

  // Datapath: capture on start, step one term per cycle, latch the result on the way into DONE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target   <= '0;
      a        <= '0;
      b        <= '0;
      k        <= '0;
      is_fib_q <= 1'b0;
      index_q  <= '0;
    end else if (start) begin
      target <= bus.numberIn;
      a      <= '0;
      b      <= (WIDTH+1)'(1);
      k      <= '0;
    end else if (state == RUN) begin
      if (hit) begin
        is_fib_q <= 1'b1;
        index_q  <= k;
      end else if (over) begin
        // a = 0 at k = 0 can never exceed target, so k - 1 never underflows here
        is_fib_q <= 1'b0;
        index_q  <= k - IDX_WIDTH'(1);
      end else if (at_max) begin
        is_fib_q <= 1'b0;
        index_q  <= IDX_WIDTH'(MAX_IDX);
      end else begin
        a <= b[WIDTH-1:0];
        b <= {1'b0, a} + b;
        k <= k + IDX_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fib_number_checker.sv
// tb/tb_fib_number_checker.sv - self-checking bench for fib_number_checker
module tb_fib_number_checker;

  logic clk;
  logic reset;

  fib_number_checker_if #(.WIDTH(16), .IDX_WIDTH(5)) bus ();

  fib_number_checker #(.WIDTH(16), .IDX_WIDTH(5), .MAX_IDX(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fib [0:25];

  typedef struct {
    logic [15:0] value;
    bit          exp_fib;
    int          exp_idx;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Reference: scan the sequence for an exact match, else the first term above the value
  function automatic void ref_model(input int val, output bit f, output int idx, output int lat);
    f = 1'b0;
    idx = 24;
    lat = 25;
    if (val > fib[24]) return;
    for (int j = 0; j <= 24; j++) begin
      if (fib[j] == val) begin
        f = 1'b1; idx = j; lat = j + 1; return;
      end
      if (fib[j] > val) begin
        idx = j - 1; lat = j + 1; return;
      end
    end
  endfunction

  // One full transaction from the DONE/IDLE state, scrambling numberIn right after capture
  task automatic run_one(input logic [15:0] val, input bit exp_fib, input int exp_idx,
                         input int exp_lat, input string name);
    int   lat;
    bit   seen;
    bit   held;
    logic [4:0] old_idx;
    logic old_fib;
    @(negedge clk);
    bus.numberIn = val;
    bus.go = 1'b1;
    old_idx = bus.index;
    old_fib = bus.isFib;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    bus.numberIn = 16'($urandom);
    check({name, " busy_after_go"}, int'(bus.busy), 1);
    seen = 1'b0;
    held = 1'b1;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        lat = e;
        break;
      end
      if (bus.index !== old_idx || bus.isFib !== old_fib) held = 1'b0;
    end
    check({name, " done_seen"}, int'(seen), 1);
    check({name, " latency"}, lat, exp_lat);
    check({name, " isFib"}, int'(bus.isFib), int'(exp_fib));
    check({name, " index"}, int'(bus.index), exp_idx);
    check({name, " result_held_during_run"}, int'(held), 1);
  endtask

  initial begin
    bit   f;
    int   idx;
    int   lat;
    int   v;
    logic [11:0] pattern;
    bit   spurious;

    fib[0] = 0;
    fib[1] = 1;
    for (int j = 2; j <= 25; j++) fib[j] = fib[j-1] + fib[j-2];

    vecs[0] = '{16'd0,     1'b1, 0,  1};
    vecs[1] = '{16'd1,     1'b1, 1,  2};
    vecs[2] = '{16'd2,     1'b1, 3,  4};
    vecs[3] = '{16'd4,     1'b0, 4,  6};
    vecs[4] = '{16'd100,   1'b0, 11, 13};
    vecs[5] = '{16'd6765,  1'b1, 20, 21};
    vecs[6] = '{16'd46367, 1'b0, 23, 25};
    vecs[7] = '{16'd46368, 1'b1, 24, 25};
    vecs[8] = '{16'd46369, 1'b0, 24, 25};
    vecs[9] = '{16'd65535, 1'b0, 24, 25};

    reset = 1'b0;
    bus.go = 1'b0;
    bus.numberIn = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset done", int'(bus.done), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset isFib", int'(bus.isFib), 0);
    check("reset index", int'(bus.index), 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++)
      run_one(vecs[i].value, vecs[i].exp_fib, vecs[i].exp_idx, vecs[i].exp_lat,
              $sformatf("vec%0d(%0d)", i, vecs[i].value));

    // go pulse and numberIn change during RUN must be ignored
    @(negedge clk);
    bus.numberIn = 16'd6765;
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (e == 2) begin
        bus.go = 1'b1;
        bus.numberIn = 16'd100;
      end else begin
        bus.go = 1'b0;
        bus.numberIn = 16'd0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = e;
        break;
      end
    end
    bus.go = 1'b0;
    check("go_in_run latency", lat, 21);
    check("go_in_run isFib", int'(bus.isFib), 1);
    check("go_in_run index", int'(bus.index), 20);

    // Back-to-back restart with go held high in DONE
    run_one(16'd100, 1'b0, 11, 13, "b2b_pre");
    @(negedge clk);
    bus.numberIn = 16'd3;
    bus.go = 1'b1;
    pattern = '0;
    for (int r = 0; r < 12; r++) begin
      @(posedge clk);
      #1;
      pattern[r] = bus.done;
      if (r == 1) begin
        check("b2b old isFib kept", int'(bus.isFib), 0);
        check("b2b old index kept", int'(bus.index), 11);
      end
      if (r == 5) begin
        check("b2b isFib", int'(bus.isFib), 1);
        check("b2b index", int'(bus.index), 4);
      end
    end
    @(negedge clk);
    bus.go = 1'b0;
    check("b2b done pattern", int'(pattern), int'(12'b1000_0010_0000));

    // Asynchronous reset in the middle of a search
    @(negedge clk);
    bus.numberIn = 16'd46368;
    bus.go = 1'b1;
    @(posedge clk);
    #1;
    bus.go = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrun reset done", int'(bus.done), 0);
    check("midrun reset busy", int'(bus.busy), 0);
    check("midrun reset isFib", int'(bus.isFib), 0);
    check("midrun reset index", int'(bus.index), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    spurious = 1'b0;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) spurious = 1'b1;
    end
    check("post reset idle", int'(spurious), 0);

    // Generator round trip: every F(k) maps back to k (value 1 always reports 1)
    for (int j = 0; j <= 24; j++) begin
      ref_model(fib[j], f, idx, lat);
      check($sformatf("sweep k%0d ref", j), idx, (j == 2) ? 1 : j);
      run_one(16'(fib[j]), f, idx, lat, $sformatf("sweep k%0d", j));
    end

    // Randomized values, biased toward sequence terms and their neighbours
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 2))
        0: v = int'($urandom_range(0, 65535));
        1: begin
          v = fib[$urandom_range(0, 24)] + int'($urandom_range(0, 2)) - 1;
          if (v < 0) v = 0;
        end
        default: v = int'($urandom_range(46360, 65535));
      endcase
      ref_model(v, f, idx, lat);
      run_one(16'(v), f, idx, lat, $sformatf("rand%0d(%0d)", i, v));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
